// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line idle level, baud divisor helper.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;
  localparam uart_state_t ST_DONE   = 3'd5;

  localparam logic IDLE_LINE = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick pulses on terminal count.
// clr dominates en; no backpressure, the caller decides what a tick means.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART Tx serializer: shifts a held byte out as start/data/[parity]/stop; all outputs registered.
// No backpressure: load is ignored while busy or done, and only tx_clear=0 aborts a frame.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 transmit,
  input  logic                 tx_clear,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_serial,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_done_q, tx_done_d;
  logic                 busy_q, busy_d;

  logic in_frame;
  logic baud_clr;
  logic baud_tick;
  logic parity_bit;

  assign in_frame   = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign baud_clr   = !tx_clear || !in_frame;
  assign parity_bit = (^hold_q) ^ (PARITY_ODD != 0);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .en   (in_frame),
    .tick (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bit_idx_d = bit_idx_q;
    if (!tx_clear) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
    end else begin
      // The holding register is frozen for the whole frame and while done is pending.
      if (load && !busy_q && (state_q != ST_DONE)) begin
        hold_d = data_in;
      end
      case (state_q)
        ST_IDLE: begin
          if (!load && transmit) state_d = ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_d = '0;
              state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (baud_tick) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_serial_d = IDLE_LINE;
    busy_d      = 1'b0;
    tx_done_d   = 1'b0;
    case (state_d)
      ST_START: begin
        tx_serial_d = 1'b0;
        busy_d      = 1'b1;
      end
      ST_DATA: begin
        tx_serial_d = hold_q[bit_idx_d];
        busy_d      = 1'b1;
      end
      ST_PARITY: begin
        tx_serial_d = parity_bit;
        busy_d      = 1'b1;
      end
      ST_STOP: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        tx_done_d = 1'b1;
      end
      default: begin
        tx_serial_d = IDLE_LINE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      bit_idx_q   <= '0;
      tx_serial_q <= IDLE_LINE;
      tx_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bit_idx_q   <= bit_idx_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_done   = tx_done_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit datapath, directly downstream of the Tx control FSM. Consumes the FSM's load, transmit and active-low clear strobes. Captures a parallel byte and shifts it out as a start/data/optional parity/stop frame on the serial line. Returns the done level that advances the FSM to its reset state.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
load  input  1  one-cycle strobe: capture data_in into the holding register
transmit  input  1  level: start a frame when idle
tx_clear  input  1  synchronous, active-low: abort or finish, return to IDLE
data_in  input  DATA_BITS  parallel data to send
tx_serial  output  1  UART line, idle high
tx_done  output  1  level: frame complete, held until tx_clear = 0
busy  output  1  high from the start-bit cycle through the last stop-bit cycle

Behaviour:
- Reset (async, reset = 0): state = IDLE, tx_serial = 1, tx_done = 0, busy = 0, holding reg = 0, baud cnt = 0, bit idx = 0.
- States: IDLE, START, DATA, PARITY, STOP, DONE. All outputs are registered.
- Priority per cycle: tx_clear = 0 > load > transmit.
- tx_clear = 0 in any state:
  - next cycle state = IDLE, tx_serial = 1, tx_done = 0, busy = 0, counters = 0;
  - holding reg is kept.
- load = 1:
  - captures data_in only when busy = 0 and state != DONE;
  - otherwise ignored, and an in-flight frame keeps its original data.
- IDLE, transmit = 1 at edge n:
  - state = START, tx_serial = 0 and busy = 1 from cycle n+1;
  - baud cnt cleared.
- Bit timing:
  - each bit occupies exactly CLKS_PER_BIT cycles;
  - baud cnt counts 0..CLKS_PER_BIT-1 and the bit advances on terminal count;
  - baud cnt width = clog2(CLKS_PER_BIT).
- DATA: LSB first. Bit idx runs 0..DATA_BITS-1 and drives tx_serial = hold[idx].
- PARITY (PARITY_EN only): bit = XOR of the DATA_BITS data bits, inverted when PARITY_ODD = 1.
- STOP: one stop bit, tx_serial = 1.
- DONE:
  - entered on terminal count of STOP; busy = 0, tx_done = 1, tx_serial = 1;
  - remains in DONE until tx_clear = 0, regardless of transmit.
- Frame length F = (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles. tx_done rises F cycles after the first start-bit cycle.
- transmit deasserting mid-frame has no effect; the frame completes (no abort without tx_clear).
- transmit held high in IDLE after a clear starts a new frame with the current holding reg.
- Async reset mid-frame: line returns high immediately; no partial frame is resumed.

Decomposition:
- Package uart_pkg holds:
  - the state enum (3-bit encoding: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, DONE = 5);
  - a constant function clks_per_bit(CLK_FREQ, BAUD);
  - the IDLE_LINE = 1 constant.
- One sub-module, uart_baud_tick:
  - counter with clear input and a terminal-count pulse, parameterised by CLKS_PER_BIT;
  - reusable by the future receiver.

Test Plan:
- Bench parameters for scenarios 2–6: CLK_FREQ = 8, BAUD = 1, so 8 clocks/bit.
1. Assert reset = 0 mid-cycle -> tx_serial = 1, tx_done = 0, busy = 0 immediately, without waiting for a clock edge.
2. load 0xA5, then transmit = 1 (8N1) -> line shows 0,1,0,1,0,0,1,0,1,1, each for 8 cycles. tx_done rises 80 cycles after the start bit and stays high until tx_clear = 0, then falls the next cycle.
3. PARITY_EN = 1, data 0x07 -> parity bit = 1 with PARITY_ODD = 0 and 0 with PARITY_ODD = 1. tx_done arrives at 88 cycles.
4. tx_clear = 0 during data bit 3 -> next cycle tx_serial = 1, busy = 0, state IDLE, and tx_done never asserts.
5. load 0x3C while busy during a 0xA5 frame -> serialized bits remain 0xA5. A following transmit after clear sends 0xA5 again (holding reg unchanged).
6. Integrated with the control FSM: pulse request -> one load, one frame, tx_done, and a single-cycle tx_clear = 0. Back-to-back requests produce two full frames with no glitch on tx_serial between the stop bit and the next start bit.
